interrupt_arbiter: RTL

INTERRUPT_ARBITER -- requirements
Module: interrupt_arbiter

---
 rtl/pic_pkg.sv | 25 ++
 rtl/interrupt_arbiter_if.sv | 26 ++
 rtl/pic_priority_resolver.sv | 16 +
 rtl/interrupt_arbiter.sv | 90 +++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// pic_pkg: FSM state encodings, OCW2 command codes and rotating-priority rank helper shared by the arbiter
package pic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACK1 = 2'b01,
        ACK2 = 2'b11
    } state_e;

    typedef enum logic [2:0] {
        OCW_CLR_ROT    = 3'b000,
        OCW_NS_EOI     = 3'b001,
        OCW_NOP        = 3'b010,
        OCW_S_EOI      = 3'b011,
        OCW_SET_ROT    = 3'b100,
        OCW_ROT_NS_EOI = 3'b101,
        OCW_SET_PRIO   = 3'b110,
        OCW_ROT_S_EOI  = 3'b111
    } ocw2_cmd_e;

    function automatic logic [2:0] prio_rank(input logic [2:0] lvl, input logic [2:0] lp);
        return lvl - lp - 3'd1;
    endfunction

endpackage

// File: rtl/interrupt_arbiter_if.sv
// interrupt_arbiter_if: request, mask, OCW2, acknowledge and vector bus of the interrupt arbiter
interface interrupt_arbiter_if;
    logic [7:0] ir;
    logic [7:0] imr;
    logic       ltim;
    logic       aeoi;
    logic [4:0] vec_base;
    logic       ocw2_wr;
    logic [7:0] ocw2;
    logic       inta_n;
    logic       int_out;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] irr;
    logic [7:0] isr;

    modport master (
        output ir, imr, ltim, aeoi, vec_base, ocw2_wr, ocw2, inta_n,
        input  int_out, data_out, data_oe, irr, isr
    );

    modport slave (
        input  ir, imr, ltim, aeoi, vec_base, ocw2_wr, ocw2, inta_n,
        output int_out, data_out, data_oe, irr, isr
    );
endinterface

// File: rtl/pic_priority_resolver.sv
// pic_priority_resolver: highest-priority set bit of req_i when lp_i is the lowest-priority level
module pic_priority_resolver (
    input  logic [7:0] req_i,
    input  logic [2:0] lp_i,
    output logic       valid_o,
    output logic [2:0] idx_o
);
    assign valid_o = |req_i;

    // Scan from lowest to highest priority so the last hit is the winner
    always_comb begin
        idx_o = 3'd0;
        for (int k = 7; k >= 0; k--)
            if (req_i[lp_i + 3'(k + 1)]) idx_o = lp_i + 3'(k + 1);
    end
endmodule

// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter: 8-level rotating-priority interrupt arbiter with two-pulse INTA vector delivery
module interrupt_arbiter
    import pic_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    interrupt_arbiter_if.slave bus
);
    state_e     state_q, state_d;
    ocw2_cmd_e  cmd;
    logic [7:0] ir_q, irr_q, irr_d, isr_q, isr_d, set_m, clr_m, irr_in;
    logic [2:0] lp_q, lp_d, win_q, win_d, cand, isr_hi, lvl;
    logic       inta_q, int_q, int_d, rot_q, rot_d, spur_q, spur_d;
    logic       cand_v, isr_v, fall, rise, ack, done, aeoi_clr, pend, oe, ns_eoi, s_eoi;
    logic       unused_ocw2;

    pic_priority_resolver u_cand (.req_i(irr_q & ~bus.imr), .lp_i(lp_q), .valid_o(cand_v), .idx_o(cand));
    pic_priority_resolver u_isr  (.req_i(isr_q), .lp_i(lp_q), .valid_o(isr_v), .idx_o(isr_hi));

    assign cmd         = ocw2_cmd_e'(bus.ocw2[7:5]);
    assign lvl         = bus.ocw2[2:0];
    assign unused_ocw2 = ^bus.ocw2[4:3];
    assign fall        = inta_q & ~bus.inta_n;
    assign rise        = ~inta_q & bus.inta_n;
    assign ack         = (state_q == IDLE) & fall;
    assign done        = (state_q == ACK2) & rise;
    assign aeoi_clr    = done & bus.aeoi & ~spur_q;
    assign ns_eoi      = bus.ocw2_wr & isr_v & (cmd inside {OCW_NS_EOI, OCW_ROT_NS_EOI});
    assign s_eoi       = bus.ocw2_wr & (cmd inside {OCW_S_EOI, OCW_ROT_S_EOI});
    assign pend        = cand_v & (~isr_v | (prio_rank(cand, lp_q) < prio_rank(isr_hi, lp_q)));

    // Setting after clearing lets an acknowledge beat an EOI aimed at the same bit
    assign set_m  = (ack & cand_v) ? 8'b1 << cand : 8'h00;
    assign clr_m  = (aeoi_clr ? 8'b1 << win_q : 8'h00) | (ns_eoi ? 8'b1 << isr_hi : 8'h00) |
                    (s_eoi ? 8'b1 << lvl : 8'h00);
    assign irr_in = bus.ltim ? bus.ir : irr_q | (bus.ir & ~ir_q);
    assign irr_d  = irr_in & ~set_m;
    assign isr_d  = (isr_q & ~clr_m) | set_m;
    assign win_d  = ack ? (cand_v ? cand : 3'd7) : win_q;
    assign spur_d = ack ? ~cand_v : spur_q;
    assign int_d  = pend & ~ack;
    assign lp_d   = (ns_eoi & (cmd == OCW_ROT_NS_EOI)) ? isr_hi :
                    (bus.ocw2_wr & (cmd inside {OCW_ROT_S_EOI, OCW_SET_PRIO})) ? lvl :
                    (aeoi_clr & rot_q) ? win_q : lp_q;
    assign rot_d  = (bus.ocw2_wr & (cmd == OCW_SET_ROT)) |
                    (rot_q & ~(bus.ocw2_wr & (cmd == OCW_CLR_ROT)));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = fall ? ACK1 : IDLE;
            ACK1:    state_d = fall ? ACK2 : ACK1;
            ACK2:    state_d = rise ? IDLE : ACK2;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ir_q    <= 8'h00;
            irr_q   <= 8'h00;
            isr_q   <= 8'h00;
            lp_q    <= 3'd7;
            win_q   <= 3'd0;
            inta_q  <= 1'b1;
            int_q   <= 1'b0;
            rot_q   <= 1'b0;
            spur_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= bus.ir;
            irr_q   <= irr_d;
            isr_q   <= isr_d;
            lp_q    <= lp_d;
            win_q   <= win_d;
            inta_q  <= bus.inta_n;
            int_q   <= int_d;
            rot_q   <= rot_d;
            spur_q  <= spur_d;
        end
    end

    assign oe           = (state_q == ACK2) & ~bus.inta_n;
    assign bus.data_oe  = oe;
    assign bus.data_out = oe ? {bus.vec_base, win_q} : 8'h00;
    assign bus.int_out  = int_q;
    assign bus.irr      = irr_q;
    assign bus.isr      = isr_q;
endmodule
